lcz80_arith16_seq: RTL and testbench

Two-cycle sequencer that drives the 8-bit Z80 ALU to execute 16-bit `ADD HL,rr`, `ADC HL,rr` and `SBC HL,rr`. It sits between the microcode/control unit and the ALU.
- Issues the low byte, then the high byte, over the ALU's operand/flag port.
- Chains carry/borrow and the low-byte zero status from the first pass into the second.
- Returns the 16-bit result and final flags with a done pulse.

---
 rtl/lcz80_arith16_seq.sv | 121 ++++++++++++
 tb/tb_lcz80_arith16_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcz80_arith16_seq.sv
// Two-pass sequencer driving the 8-bit Z80 ALU for 16-bit ADD/ADC/SBC HL,rr.
// ADC/SBC support is enabled by LCZ80_ARITH16_ADCSBC_EN; otherwise every request runs as ADD.
module lcz80_arith16_seq (
    input  logic        CLK_n,
    input  logic        RESET_n,
    input  logic        Start,
    input  logic [1:0]  Op,
    input  logic [15:0] OpA,
    input  logic [15:0] OpB,
    input  logic [7:0]  F_In,
    output logic        Busy,
    output logic        Done,
    output logic [15:0] Result,
    output logic [7:0]  F_Res,
    output logic [3:0]  ALU_Op,
    output logic [7:0]  ALU_BusA,
    output logic [7:0]  ALU_BusB,
    output logic [7:0]  ALU_FIn,
    output logic        ALU_Arith16,
    output logic        ALU_Z16,
    input  logic [7:0]  ALU_Q,
    input  logic [7:0]  ALU_FOut
);

    typedef enum logic [1:0] {IDLE, LO, HI} state_t;

    state_t     state;
    logic [7:0] a_hi;
    logic [7:0] b_hi;
    logic [7:0] lo_q;
    logic [7:0] f_reg;
    logic       is_add;
    logic       is_sbc;

    logic       req_add;
    logic       req_sbc;

`ifdef LCZ80_ARITH16_ADCSBC_EN
    // Reserved encoding 11 falls back to ADD.
    assign req_add = (Op == 2'b00) || (Op == 2'b11);
    assign req_sbc = (Op == 2'b10);
`else
    logic unused_op;
    assign unused_op = ^Op;
    assign req_add   = 1'b1;
    assign req_sbc   = 1'b0;
`endif

    always_ff @(posedge CLK_n or negedge RESET_n) begin
        if (!RESET_n) begin
            state       <= IDLE;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            Result      <= 16'h0000;
            F_Res       <= 8'h00;
            ALU_Op      <= 4'h0;
            ALU_BusA    <= 8'h00;
            ALU_BusB    <= 8'h00;
            ALU_FIn     <= 8'h00;
            ALU_Arith16 <= 1'b0;
            ALU_Z16     <= 1'b0;
            a_hi        <= 8'h00;
            b_hi        <= 8'h00;
            lo_q        <= 8'h00;
            f_reg       <= 8'h00;
            is_add      <= 1'b0;
            is_sbc      <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start) begin
                        state       <= LO;
                        Busy        <= 1'b1;
                        a_hi        <= OpA[15:8];
                        b_hi        <= OpB[15:8];
                        f_reg       <= F_In;
                        is_add      <= req_add;
                        is_sbc      <= req_sbc;
                        // Low pass: ADD -> 0000, ADC -> 0001, SBC -> 0011
                        ALU_Op      <= {2'b00, req_sbc, ~req_add};
                        ALU_BusA    <= OpA[7:0];
                        ALU_BusB    <= OpB[7:0];
                        ALU_FIn     <= F_In;
                        ALU_Arith16 <= req_add;
                        ALU_Z16     <= 1'b0;
                    end
                end
                LO: begin
                    state    <= HI;
                    lo_q     <= ALU_Q;
                    // High pass always chains carry/borrow; ADC/SBC also chain low-byte zero
                    ALU_Op   <= {2'b00, is_sbc, 1'b1};
                    ALU_BusA <= a_hi;
                    ALU_BusB <= b_hi;
                    ALU_FIn  <= {f_reg[7], is_add ? f_reg[6] : (ALU_Q == 8'h00),
                                 f_reg[5:1], ALU_FOut[0]};
                    ALU_Z16  <= ~is_add;
                end
                HI: begin
                    state       <= IDLE;
                    Busy        <= 1'b0;
                    Done        <= 1'b1;
                    Result      <= {ALU_Q, lo_q};
                    F_Res       <= ALU_FOut;
                    ALU_Op      <= 4'h0;
                    ALU_BusA    <= 8'h00;
                    ALU_BusB    <= 8'h00;
                    ALU_FIn     <= 8'h00;
                    ALU_Arith16 <= 1'b0;
                    ALU_Z16     <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcz80_arith16_seq.sv
// Bench for lcz80_arith16_seq: byte-level Z80 ALU stand-in plus a 16-bit arithmetic reference.
// Honours LCZ80_ARITH16_ADCSBC_EN when deciding which operation a request should execute.
module tb_lcz80_arith16_seq;

    logic        CLK_n;
    logic        RESET_n;
    logic        Start;
    logic [1:0]  Op;
    logic [15:0] OpA;
    logic [15:0] OpB;
    logic [7:0]  F_In;
    logic        Busy;
    logic        Done;
    logic [15:0] Result;
    logic [7:0]  F_Res;
    logic [3:0]  ALU_Op;
    logic [7:0]  ALU_BusA;
    logic [7:0]  ALU_BusB;
    logic [7:0]  ALU_FIn;
    logic        ALU_Arith16;
    logic        ALU_Z16;
    logic [7:0]  ALU_Q;
    logic [7:0]  ALU_FOut;

    int n_cmp = 0;
    int n_err = 0;

    lcz80_arith16_seq dut (
        .CLK_n       (CLK_n),
        .RESET_n     (RESET_n),
        .Start       (Start),
        .Op          (Op),
        .OpA         (OpA),
        .OpB         (OpB),
        .F_In        (F_In),
        .Busy        (Busy),
        .Done        (Done),
        .Result      (Result),
        .F_Res       (F_Res),
        .ALU_Op      (ALU_Op),
        .ALU_BusA    (ALU_BusA),
        .ALU_BusB    (ALU_BusB),
        .ALU_FIn     (ALU_FIn),
        .ALU_Arith16 (ALU_Arith16),
        .ALU_Z16     (ALU_Z16),
        .ALU_Q       (ALU_Q),
        .ALU_FOut    (ALU_FOut)
    );

    initial CLK_n = 1'b0;
    always #5 CLK_n = ~CLK_n;

    // Z80 8-bit ALU (add/adc/sbc subset) returning {flags, q}
    function automatic logic [15:0] alu8(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b, input logic [7:0] fin,
                                         input logic ar16, input logic z16);
        logic       sub;
        logic       cin;
        logic [8:0] full;
        logic [4:0] half;
        logic [7:0] q;
        logic       v;
        logic       z;
        logic [7:0] f;
        sub = op[1];
        cin = op[0] ? fin[0] : 1'b0;
        if (sub) begin
            full = {1'b0, a} - {1'b0, b} - 9'(cin);
            half = {1'b0, a[3:0]} - {1'b0, b[3:0]} - 5'(cin);
        end else begin
            full = {1'b0, a} + {1'b0, b} + 9'(cin);
            half = {1'b0, a[3:0]} + {1'b0, b[3:0]} + 5'(cin);
        end
        q = full[7:0];
        v = sub ? ((a[7] != b[7]) && (q[7] != a[7])) : ((a[7] == b[7]) && (q[7] != a[7]));
        z = (q == 8'h00) ? (z16 ? fin[6] : 1'b1) : 1'b0;
        f = {q[7], z, q[5], half[4], q[3], v, sub, full[8]};
        if (ar16) begin
            f[7] = fin[7];
            f[6] = fin[6];
            f[2] = fin[2];
        end
        return {f, q};
    endfunction

    assign {ALU_FOut, ALU_Q} = alu8(ALU_Op, ALU_BusA, ALU_BusB, ALU_FIn, ALU_Arith16, ALU_Z16);

    // Operation actually executed: 0 = ADD, 1 = ADC, 2 = SBC
    function automatic int eff_op(input logic [1:0] op);
`ifdef LCZ80_ARITH16_ADCSBC_EN
        return (op == 2'b11) ? 0 : int'(op);
`else
        return (op == 2'b11) ? 0 : 0;
`endif
    endfunction

    // Whole-word reference: {flags, result}
    function automatic logic [23:0] ref16(input int op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] f);
        logic [16:0] full;
        logic [12:0] half;
        logic [15:0] r;
        logic        c;
        logic        v;
        logic [7:0]  fo;
        c = (op == 0) ? 1'b0 : f[0];
        if (op == 2) begin
            full = {1'b0, a} - {1'b0, b} - 17'(c);
            half = {1'b0, a[11:0]} - {1'b0, b[11:0]} - 13'(c);
        end else begin
            full = {1'b0, a} + {1'b0, b} + 17'(c);
            half = {1'b0, a[11:0]} + {1'b0, b[11:0]} + 13'(c);
        end
        r  = full[15:0];
        v  = (op == 2) ? ((a[15] != b[15]) && (r[15] != a[15]))
                       : ((a[15] == b[15]) && (r[15] != a[15]));
        fo = {r[15], r == 16'h0000, r[13], half[12], r[11], v, op == 2, full[16]};
        if (op == 0) begin
            fo[7] = f[7];
            fo[6] = f[6];
            fo[2] = f[2];
        end
        return {fo, r};
    endfunction

    task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, 24'(Busy), 24'(1'b0));
        chk({tag, "_done"}, 24'(Done), 24'(1'b0));
        chk({tag, "_result"}, 24'(Result), 24'(16'h0000));
        chk({tag, "_fres"}, 24'(F_Res), 24'(8'h00));
        chk({tag, "_alu"}, 24'({ALU_Op, ALU_BusA, ALU_BusB, ALU_FIn, ALU_Arith16, ALU_Z16}) ,
            24'(0));
    endtask

    // One full transaction with fixed-latency checks in LO, HI and the Done cycle
    task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] f);
        int          eop;
        logic [23:0] exp;
        logic [8:0]  lo_full;
        logic        lo_c;
        logic        cin;
        eop = eff_op(op);
        exp = ref16(eop, a, b, f);
        cin = (eop == 0) ? 1'b0 : f[0];
        lo_full = (eop == 2) ? ({1'b0, a[7:0]} - {1'b0, b[7:0]} - 9'(cin))
                             : ({1'b0, a[7:0]} + {1'b0, b[7:0]} + 9'(cin));
        lo_c = lo_full[8];
        @(negedge CLK_n);
        Op = op; OpA = a; OpB = b; F_In = f; Start = 1'b1;
        @(posedge CLK_n);
        #1;
        Start = 1'b0;
        chk("lo_busy", 24'(Busy), 24'(1'b1));
        chk("lo_done", 24'(Done), 24'(1'b0));
        chk("lo_bus", 24'({ALU_BusA, ALU_BusB}), 24'({a[7:0], b[7:0]}));
        chk("lo_fin", 24'(ALU_FIn), 24'(f));
        chk("lo_op", 24'(ALU_Op), (eop == 0) ? 24'h0 : (eop == 1) ? 24'h1 : 24'h3);
        chk("lo_ar16_z16", 24'({ALU_Arith16, ALU_Z16}), 24'({eop == 0, 1'b0}));
        // Operand inputs change after acceptance and must not matter
        Op = 2'($urandom); OpA = 16'($urandom); OpB = 16'($urandom); F_In = 8'($urandom);
        @(posedge CLK_n);
        #1;
        chk("hi_busy", 24'(Busy), 24'(1'b1));
        chk("hi_bus", 24'({ALU_BusA, ALU_BusB}), 24'({a[15:8], b[15:8]}));
        chk("hi_fin", 24'(ALU_FIn),
            24'({f[7], (eop == 0) ? f[6] : (lo_full[7:0] == 8'h00), f[5:1], lo_c}));
        chk("hi_op", 24'(ALU_Op), (eop == 2) ? 24'h3 : 24'h1);
        chk("hi_ar16_z16", 24'({ALU_Arith16, ALU_Z16}), 24'({eop == 0, eop != 0}));
        @(posedge CLK_n);
        #1;
        chk("done_pulse", 24'({Done, Busy}), 24'(2'b10));
        chk("result", 24'(Result), 24'(exp[15:0]));
        chk("f_res", 24'(F_Res), 24'(exp[23:16]));
        chk("done_alu_op", 24'(ALU_Op), 24'(0));
        $display("op=%0d a=%h b=%h f=%h -> result=%h f_res=%h (ref %h %h)",
                 op, a, b, f, Result, F_Res, exp[15:0], exp[23:16]);
    endtask

    initial begin
        logic [23:0] exp;
        RESET_n = 1'b0;
        Start   = 1'b0;
        Op      = 2'b00;
        OpA     = 16'h0000;
        OpB     = 16'h0000;
        F_In    = 8'h00;
        #12;
        chk_idle_outputs("reset");
        @(negedge CLK_n);
        RESET_n = 1'b1;
        @(posedge CLK_n);
        #1;
        chk_idle_outputs("post_reset");

        // Directed cases from the worked examples
        run_op(2'b00, 16'h0FFF, 16'h0001, 8'hC4);
        chk("tp_add", 24'({F_Res, Result}), 24'h D41000);
`ifdef LCZ80_ARITH16_ADCSBC_EN
        run_op(2'b01, 16'hFFFF, 16'h0000, 8'h01);
        chk("tp_adc", 24'({F_Res, Result}), 24'h510000);
        run_op(2'b10, 16'h8000, 16'h0001, 8'h00);
        chk("tp_sbc", 24'({F_Res, Result}), 24'h3E7FFF);
        run_op(2'b01, 16'h0100, 16'h0000, 8'h00);
        chk("tp_adc_zsplit", 24'({F_Res, Result}), 24'h000100);
        run_op(2'b10, 16'h0100, 16'h0100, 8'h00);
        chk("tp_sbc_zero", 24'({F_Res, Result}), 24'h420000);
`else
        run_op(2'b01, 16'hFFFF, 16'h0000, 8'h01);
        run_op(2'b10, 16'h8000, 16'h0001, 8'h00);
        run_op(2'b01, 16'h0100, 16'h0000, 8'h00);
        run_op(2'b10, 16'h0100, 16'h0100, 8'h00);
`endif
        run_op(2'b11, 16'h7FFF, 16'h0001, 8'h00);

        for (int i = 0; i < 30; i++) begin
            run_op(2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom), 8'($urandom));
        end

        // Start held high: accepted every third edge
        @(negedge CLK_n);
        Op = 2'b01; OpA = 16'h1234; OpB = 16'h0F0F; F_In = 8'h01; Start = 1'b1;
        exp = ref16(eff_op(2'b01), 16'h1234, 16'h0F0F, 8'h01);
        @(posedge CLK_n);
        for (int i = 0; i < 9; i++) begin
            #1;
            chk("held_done", 24'(Done), 24'(i % 3 == 2));
            chk("held_busy", 24'(Busy), 24'(i % 3 != 2));
            if (i % 3 == 2) begin
                chk("held_result", 24'({F_Res, Result}), exp);
                $display("held start: done at cycle %0d result=%h f_res=%h", i, Result, F_Res);
            end
            @(posedge CLK_n);
        end
        #1;
        Start = 1'b0;
        repeat (3) @(posedge CLK_n);

        // Start pulsed during LO is neither taken nor queued
        @(negedge CLK_n);
        Op = 2'b00; OpA = 16'h00FF; OpB = 16'h0001; F_In = 8'h00; Start = 1'b1;
        exp = ref16(0, 16'h00FF, 16'h0001, 8'h00);
        @(posedge CLK_n);
        #1;
        Start = 1'b0;
        @(negedge CLK_n);
        OpA = 16'hAAAA; OpB = 16'h5555; Start = 1'b1;
        @(posedge CLK_n);
        #1;
        Start = 1'b0;
        @(posedge CLK_n);
        #1;
        chk("lo_pulse_done", 24'(Done), 24'(1'b1));
        chk("lo_pulse_result", 24'({F_Res, Result}), exp);
        @(posedge CLK_n);
        #1;
        chk("lo_pulse_not_queued", 24'({Done, Busy}), 24'(2'b00));
        $display("start during LO: result=%h f_res=%h", Result, F_Res);

        // Asynchronous reset while in HI
        @(negedge CLK_n);
        Op = 2'b00; OpA = 16'h1111; OpB = 16'h2222; F_In = 8'h00; Start = 1'b1;
        @(posedge CLK_n);
        #1;
        Start = 1'b0;
        @(posedge CLK_n);
        #1;
        chk("hi_before_reset", 24'(Busy), 24'(1'b1));
        #2;
        RESET_n = 1'b0;
        #1;
        chk_idle_outputs("mid_reset");
        @(negedge CLK_n);
        RESET_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK_n);
            #1;
            chk("no_done_after_reset", 24'({Done, Busy}), 24'(2'b00));
        end
        $display("reset during HI: busy=%0d done=%0d result=%h", Busy, Done, Result);
        run_op(2'b10, 16'h0005, 16'h0007, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
